// File: rtl/fpu_exec_ctrl.sv
// fpu_exec_ctrl: multi-cycle RV32F arithmetic sequencer (stall, unit handshake, write-back, sticky flags).
// Define FPU_FFLAGS_EN to build the accrued exception-flag register; otherwise fflags reads as zero.
module fpu_exec_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fpu_en,
    input  logic [4:0]  fpu_op,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        stall,
    output logic        illegal_instr,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] unit_result,
    input  logic [4:0]  unit_flags,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        fflags_clr,
    output logic [4:0]  fflags
);
    localparam int MAX_AM = ADD_LAT > MUL_LAT ? ADD_LAT : MUL_LAT;
    localparam int MAX_LAT = MAX_AM > DIV_LAT ? MAX_AM : DIV_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q;
    logic [1:0]    op_q;
    logic [31:0]   a_q, b_q, data_q;
    logic [4:0]    rd_q;
    logic          accept, capture;

    assign accept        = state_q == IDLE && fpu_en && fpu_op <= 5'd3;
    assign capture       = state_q == EXEC && cnt_q == '0;
    assign illegal_instr = state_q == IDLE && fpu_en && fpu_op > 5'd3;
    assign stall         = accept || state_q == EXEC;
    assign wb_valid      = state_q == WB;
    assign unit_start    = start_q;
    assign unit_op       = op_q;
    assign unit_a        = a_q;
    assign unit_b        = b_q;
    assign wb_rd         = rd_q;
    assign wb_data       = data_q;

    always_comb begin
        state_d = accept ? EXEC : capture ? WB : state_q == WB ? IDLE : state_q;
        cnt_d = accept ? (fpu_op[1] ? (fpu_op[0] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1)) : CW'(ADD_LAT - 1))
              : (state_q == EXEC && !capture) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= accept;
            if (accept) begin
                op_q <= fpu_op[1:0];
                a_q  <= rs1_val;
                b_q  <= rs2_val;
                rd_q <= rd_in;
            end
            if (capture) data_q <= unit_result;
        end
    end

`ifdef FPU_FFLAGS_EN
    logic [4:0] fflags_q;
    assign fflags = fflags_q;
    // A clear that coincides with a capture keeps only the new flags.
    always_ff @(posedge clk) begin
        if (rst) fflags_q <= '0;
        else if (capture) fflags_q <= fflags_clr ? unit_flags : fflags_q | unit_flags;
        else if (fflags_clr) fflags_q <= '0;
    end
`else
    logic unused_flags;
    assign unused_flags = ^{unit_flags, fflags_clr};
    assign fflags = '0;
`endif
endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// tb_fpu_exec_ctrl: directed plus randomized checks of fpu_exec_ctrl against a cycle-count reference model.
module tb_fpu_exec_ctrl;
    localparam int ADD_LAT = 3, MUL_LAT = 4, DIV_LAT = 16;
`ifdef FPU_FFLAGS_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, fpu_en = 1'b0, fflags_clr = 1'b0;
    logic [4:0]  fpu_op = '0, rd_in = '0, unit_flags = '0;
    logic [31:0] rs1_val = '0, rs2_val = '0, unit_result = '0;
    logic        stall, illegal_instr, unit_start, wb_valid;
    logic [1:0]  unit_op;
    logic [31:0] unit_a, unit_b, wb_data;
    logic [4:0]  wb_rd, fflags;

    int          tests = 0, fails = 0;
    logic [4:0]  exp_ff = '0, last_rd = '0;
    logic [31:0] last_data = '0;

    fpu_exec_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .fpu_en(fpu_en), .fpu_op(fpu_op), .rd_in(rd_in),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .stall(stall), .illegal_instr(illegal_instr),
        .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_result(unit_result), .unit_flags(unit_flags), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .fflags_clr(fflags_clr), .fflags(fflags)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [1:0] op);
        return op == 2'd3 ? DIV_LAT : op == 2'd2 ? MUL_LAT : ADD_LAT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle: optionally an unsupported op and/or a flag clear.
    task automatic idle_cycle(input bit en, input logic [4:0] op, input bit clr);
        fpu_en = en; fpu_op = op; fflags_clr = clr;
        rd_in = 5'($urandom); rs1_val = $urandom; rs2_val = $urandom;
        unit_result = $urandom; unit_flags = 5'($urandom);
        #4;
        check("idle_stall", 32'(stall), 32'(0));
        check("idle_illegal", 32'(illegal_instr), 32'(en));
        check("idle_start", 32'(unit_start), 32'(0));
        check("idle_wb_valid", 32'(wb_valid), 32'(0));
        check("idle_wb_rd", 32'(wb_rd), 32'(last_rd));
        check("idle_wb_data", wb_data, last_data);
        check("idle_fflags", 32'(fflags), 32'(exp_ff));
        tick();
        fflags_clr = 1'b0;
        if (clr) exp_ff = '0;
    endtask

    // Full instruction from accept through write-back; unit_result ramps so only the right cycle matches.
    task automatic do_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [4:0] flg, input bit clr_cap);
        int lat = lat_of(op);
        logic [4:0] ff_after = FF_EN ? (clr_cap ? flg : exp_ff | flg) : 5'd0;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k == 0 || k == lat + 1) begin
                fpu_en = 1'b1; fpu_op = {3'b0, op}; rd_in = rd; rs1_val = a; rs2_val = b;
            end else begin
                fpu_en = 1'($urandom); fpu_op = 5'($urandom); rd_in = 5'($urandom);
                rs1_val = $urandom; rs2_val = $urandom;
            end
            unit_result = res + 32'(k);
            unit_flags = k == lat ? flg : ~flg;
            fflags_clr = clr_cap && k == lat;
            #4;
            check("stall", 32'(stall), 32'(k <= lat));
            check("illegal_busy", 32'(illegal_instr), 32'(0));
            check("unit_start", 32'(unit_start), 32'(k == 1));
            check("wb_valid", 32'(wb_valid), 32'(k == lat + 1));
            check("fflags", 32'(fflags), 32'(k <= lat ? exp_ff : ff_after));
            if (k >= 1) begin
                check("unit_op", 32'(unit_op), 32'(op));
                check("unit_a", unit_a, a);
                check("unit_b", unit_b, b);
            end
            if (k == lat + 1) begin
                check("wb_rd", 32'(wb_rd), 32'(rd));
                check("wb_data", wb_data, res + 32'(lat));
            end
            tick();
        end
        fpu_en = 1'b0; fflags_clr = 1'b0;
        exp_ff = ff_after; last_rd = rd; last_data = res + 32'(lat);
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        idle_cycle(1'b0, 5'd0, 1'b0);

        do_op(2'd0, 5'd5, 32'h3F800000, 32'h40000000, 32'h40400000 - 32'(ADD_LAT), 5'b00001, 1'b0);
        idle_cycle(1'b0, 5'd0, 1'b0);
        do_op(2'd3, 5'd9, 32'h41200000, 32'h40800000, 32'h40200000 - 32'(DIV_LAT), 5'b10000, 1'b0);
        idle_cycle(1'b0, 5'd0, 1'b1);
        idle_cycle(1'b0, 5'd0, 1'b0);

        idle_cycle(1'b1, 5'd31, 1'b0);
        idle_cycle(1'b1, 5'($urandom_range(4, 30)), 1'b0);
        idle_cycle(1'b0, 5'd0, 1'b0);

        // FMUL aborted by reset in its third EXEC cycle
        fpu_en = 1'b1; fpu_op = 5'd2; rd_in = 5'd7; rs1_val = 32'h40400000; rs2_val = 32'h40A00000;
        unit_flags = 5'b11111; unit_result = 32'hDEADBEEF;
        tick();
        fpu_en = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #4;
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_start", 32'(unit_start), 32'(0));
        check("rst_unit_op", 32'(unit_op), 32'(0));
        check("rst_unit_a", unit_a, 32'(0));
        check("rst_unit_b", unit_b, 32'(0));
        check("rst_wb_valid", 32'(wb_valid), 32'(0));
        check("rst_wb_rd", 32'(wb_rd), 32'(0));
        check("rst_wb_data", wb_data, 32'(0));
        check("rst_fflags", 32'(fflags), 32'(0));
        tick();
        exp_ff = '0; last_rd = '0; last_data = '0;
        idle_cycle(1'b0, 5'd0, 1'b0);
        do_op(2'd1, 5'd12, 32'h40E00000, 32'h3F800000, 32'h40C00000 - 32'(ADD_LAT), 5'b00100, 1'b0);

        // back-to-back FADD then FSUB with fpu_en held through write-back
        do_op(2'd0, 5'd1, $urandom, $urandom, $urandom, 5'b00010, 1'b0);
        do_op(2'd1, 5'd2, $urandom, $urandom, $urandom, 5'b01000, 1'b0);
        idle_cycle(1'b0, 5'd0, 1'b0);

        // clear coinciding with a capture
        do_op(2'd2, 5'd3, $urandom, $urandom, $urandom, 5'b00001, 1'b1);
        idle_cycle(1'b0, 5'd0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                if ($urandom_range(0, 1) == 1) idle_cycle(1'b1, 5'($urandom_range(4, 31)), 1'($urandom_range(0, 3) == 0));
                else idle_cycle(1'b0, 5'($urandom), 1'($urandom_range(0, 3) == 0));
            do_op(2'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 4) == 0));
        end
        idle_cycle(1'b0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
